// File: rtl/johnson_seq_gen_if.sv
// Bundle of control inputs and status outputs for johnson_seq_gen.
// master: drives en/mode/dir/load/load_val/div, observes out/phase/step_tick/wrap/illegal.
// slave:  the generator itself.
interface johnson_seq_gen_if #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 8
);
  localparam int unsigned PhaseW = $clog2(2 * WIDTH);

  logic                  en;
  logic [1:0]            mode;
  logic                  dir;
  logic                  load;
  logic [WIDTH-1:0]      load_val;
  logic [PRESCALE_W-1:0] div;
  logic [WIDTH-1:0]      out;
  logic [PhaseW-1:0]     phase;
  logic                  step_tick;
  logic                  wrap;
  logic                  illegal;

  modport master (
    output en, mode, dir, load, load_val, div,
    input  out, phase, step_tick, wrap, illegal
  );

  modport slave (
    input  en, mode, dir, load, load_val, div,
    output out, phase, step_tick, wrap, illegal
  );
endinterface

// File: rtl/johnson_seq_gen.sv
// Johnson / one-hot ring phase-sequence generator with prescaler, load, self-correction,
// phase decode and wrap pulse.
// Ports:
//   clk  - clock, all state on rising edge
//   r    - asynchronous active-high reset
//   bus  - johnson_seq_gen_if.slave: en, mode, dir, load, load_val, div in;
//          out, phase, step_tick, wrap, illegal out
module johnson_seq_gen #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 8
) (
  input logic              clk,
  input logic              r,
  johnson_seq_gen_if.slave bus
);
  localparam int unsigned PhaseW = $clog2(2 * WIDTH);

  logic [WIDTH-1:0]      out_q, out_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic                  step_tick_q, step_tick_d;
  logic                  wrap_q, wrap_d;

  logic        is_johnson, is_ring, legal, step_cond;
  int unsigned ones, edges, ring_idx, phase_int, last_phase;

  // Code classification and phase decode of the current register value.
  always_comb begin
    ones     = 0;
    edges    = 0;
    ring_idx = 0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      ones = ones + 32'(out_q[i]);
      if (out_q[i]) ring_idx = 32'(i);
    end
    // A legal Johnson code has at most one 0/1 boundary between adjacent bits.
    for (int i = 0; i < int'(WIDTH) - 1; i++) begin
      edges = edges + 32'(out_q[i] ^ out_q[i+1]);
    end

    is_johnson = (bus.mode == 2'b00);
    is_ring    = (bus.mode == 2'b01);
    legal      = (is_johnson && edges <= 1) || (is_ring && ones == 1);
    last_phase = is_johnson ? 2 * WIDTH - 1 : WIDTH - 1;

    phase_int = 0;
    if (legal) begin
      if (is_johnson) phase_int = out_q[WIDTH-1] ? 2 * WIDTH - ones : ones;
      else            phase_int = ring_idx;
    end
  end

  always_comb begin
    out_d       = out_q;
    cnt_d       = cnt_q;
    step_tick_d = 1'b0;
    wrap_d      = 1'b0;
    step_cond   = 1'b0;

    if (bus.load) begin
      out_d = bus.load_val;
      cnt_d = '0;
    end else if (bus.en) begin
      // >= so that lowering div mid-count cannot overrun the new period.
      if (cnt_q >= bus.div) begin
        step_cond = 1'b1;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + PRESCALE_W'(1);
      end

      if (step_cond && (is_johnson || is_ring)) begin
        step_tick_d = 1'b1;
        if (!legal) begin
          out_d = is_johnson ? '0 : WIDTH'(1);
        end else begin
          if (!bus.dir) begin
            out_d  = is_johnson ? {out_q[WIDTH-2:0], ~out_q[WIDTH-1]}
                                : {out_q[WIDTH-2:0], out_q[WIDTH-1]};
            wrap_d = (phase_int == last_phase);
          end else begin
            out_d  = is_johnson ? {~out_q[0], out_q[WIDTH-1:1]}
                                : {out_q[0], out_q[WIDTH-1:1]};
            wrap_d = (phase_int == 0);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      out_q       <= '0;
      cnt_q       <= '0;
      step_tick_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      out_q       <= out_d;
      cnt_q       <= cnt_d;
      step_tick_q <= step_tick_d;
      wrap_q      <= wrap_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.phase     = PhaseW'(phase_int);
  assign bus.step_tick = step_tick_q;
  assign bus.wrap      = wrap_q;
  assign bus.illegal   = (is_johnson || is_ring) && !legal;
endmodule
